key_cmd_queue: RTL and testbench
================================

# key_cmd_queue

Turns the keyboard's 9-bit key code into discrete game commands (move up/down/left/right, restart, confirm) and queues them in a small FIFO. The game logic drains the queue one command per handshake, so rapid keypresses are neither lost nor double-counted. It sits between the PS/2 keyboard decoder and the VGA game engine, optionally generating auto-repeat for held movement keys.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16
- REPEAT_DELAY, 12_500_000: cycles a movement key must be held before the first repeat (0.5 s at 25 MHz)
- REPEAT_PERIOD, 2_500_000: cycles between subsequent repeats (0.1 s at 25 MHz)
- clk  in  1  game clock; all logic is on the rising edge
- rst  in  1  reset; synchronous, active-high
- key_code  in  9  from the keyboard decoder, synchronous to clk; [8] = key held, [7:0] = ASCII of the held key
- cmd_ready  in  1  the game consumes the head entry this cycle
- cmd_valid  out  1  the FIFO is non-empty
- cmd  out  3  head command: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 RESTART, 5 CONFIRM; 6 and 7 are never produced
- count  out  $clog2(DEPTH)+1  current fill level
- overflow  out  1  one-cycle pulse when a command is dropped because the FIFO is full

## Operation
- The previous key_code is held in register prev.
- A press event occurs in a cycle when key_code[8]=1 and either prev[8]=0, or prev[7:0]≠key_code[7:0].
- Mapping of key_code[7:0], case-insensitive:
  - 'w' → UP; 's' → DOWN; 'a' → LEFT; 'd' → RIGHT
  - 'r' → RESTART; 0x20 (space) → CONFIRM
  - any other code produces no command.
- A mapped press event generates a push request in the same cycle.
- Push is accepted when count<DEPTH, or when count==DEPTH and cmd_ready=1 in the same cycle (pop and push together).
- Otherwise the push is dropped, overflow=1 for that cycle, and the FIFO contents are unchanged.
- Pop occurs when cmd_valid=1 and cmd_ready=1. cmd_ready while empty is ignored.
- Simultaneous push and pop leaves count unchanged. The popped entry is the old head, and the new entry goes to the tail.
- Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count is tracked separately to distinguish full from empty.
- Key release (key_code[8] 1→0) generates nothing.
- Key change while held (e.g. 'w' to 'd' without release) counts as a new press.
- rst=1: pointers, count, prev, repeat counter and state all clear. Queued commands are discarded, including a push or pop in the same cycle.

## Timing
- Reset values: cmd_valid=0, cmd=0, count=0, overflow=0.
- Press event in cycle n → entry written at edge n+1 → cmd_valid=1 and cmd valid from cycle n+1 (1-cycle latency into an empty FIFO).
- cmd is the registered head entry. It changes only on a pop or on a write into an empty FIFO.
- Pop at edge k: count decrements and the next head appears in cycle k+1; cmd_valid drops in cycle k+1 if the FIFO became empty.
- overflow is registered and asserts in cycle n+1 for a drop in cycle n.
- Maximum throughput is one push and one pop per cycle.

## Configuration
- KEY_REPEAT_EN defined: a repeat FSM (IDLE, DELAY, REPEAT) is compiled in.
  - A mapped movement key press goes IDLE→DELAY and clears the repeat counter.
  - In DELAY, after REPEAT_DELAY cycles with the same key still held, the FSM issues a push request for the same command and moves to REPEAT.
  - In REPEAT, it issues a push every REPEAT_PERIOD cycles.
  - Release, or a change of key, returns the FSM to IDLE in the same cycle; a change of key also raises a normal press event.
  - RESTART and CONFIRM never repeat.
  - Repeat pushes obey the same full/drop/overflow rules as press pushes.
- KEY_REPEAT_EN undefined: no repeat FSM or counter exists. A held key yields exactly one command.

## Test plan
- Reset, then key_code=0x177 ('w' held) from cycle 10 → cmd_valid=1, cmd=0 and count=1 at cycle 11; hold for 100 cycles with cmd_ready=0 → count stays 1 (with KEY_REPEAT_EN, REPEAT_DELAY set to 1000).
- With cmd_ready=0, apply five distinct mapped presses separated by releases, DEPTH=4 → count=4 and one overflow pulse on the fifth; then drain with cmd_ready=1 → commands pop in press order.
- With the FIFO full, press 'd' while cmd_ready=1 in the same cycle → no overflow, count stays 4, tail entry=3.
- Press 'q' (0x171) and press 'A' (0x141) → 'q' produces no entry; 'A' produces cmd=2.
- KEY_REPEAT_EN with REPEAT_DELAY=20 and REPEAT_PERIOD=5, hold 's' for 40 cycles with cmd_ready=1 → pushes at press, press+20, +25, +30, +35; hold 'r' for 40 cycles → exactly one push.
- Assert rst for one cycle with count=3 and a push pending → count=0, cmd_valid=0 next cycle, no overflow pulse.

Source files
------------

// File: rtl/key_cmd_queue.sv
// Key code to game command translator with a small command FIFO.
// Optional auto-repeat for held movement keys is compiled in when KEY_REPEAT_EN is defined.
module key_cmd_queue #(
    parameter int DEPTH         = 4,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8:0]             key_code,
    input  logic                   cmd_ready,
    output logic                   cmd_valid,
    output logic [2:0]             cmd,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [8:0]    prev;
    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    logic       press;
    logic       map_hit;
    logic [2:0] map_cmd;
    logic       push_req, push, pop, full;
    logic [2:0] push_data;

    // Case-insensitive ASCII decode
    always_comb begin
        map_hit = 1'b1;
        map_cmd = 3'd0;
        case (key_code[7:0])
            8'h77, 8'h57: map_cmd = 3'd0;
            8'h73, 8'h53: map_cmd = 3'd1;
            8'h61, 8'h41: map_cmd = 3'd2;
            8'h64, 8'h44: map_cmd = 3'd3;
            8'h72, 8'h52: map_cmd = 3'd4;
            8'h20:        map_cmd = 3'd5;
            default:      map_hit = 1'b0;
        endcase
    end

    assign press = key_code[8] && (!prev[8] || (prev[7:0] != key_code[7:0]));

`ifdef KEY_REPEAT_EN
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    logic [1:0]  state;
    logic [31:0] rep_cnt;
    logic [2:0]  rep_cmd;
    logic        rep_push;

    // A held key without a new press means the same key is still down
    assign rep_push = key_code[8] && !press &&
                      (((state == S_DELAY)  && (rep_cnt == 32'(REPEAT_DELAY - 1))) ||
                       ((state == S_REPEAT) && (rep_cnt == 32'(REPEAT_PERIOD - 1))));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            rep_cnt <= '0;
            rep_cmd <= 3'd0;
        end else if (!key_code[8]) begin
            state   <= S_IDLE;
            rep_cnt <= '0;
        end else if (press) begin
            rep_cnt <= '0;
            if (map_hit && !map_cmd[2]) begin
                state   <= S_DELAY;
                rep_cmd <= map_cmd;
            end else begin
                state <= S_IDLE;
            end
        end else begin
            case (state)
                S_DELAY, S_REPEAT: begin
                    if (rep_push) begin
                        state   <= S_REPEAT;
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 32'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    rep_cnt <= '0;
                end
            endcase
        end
    end

    assign push_req  = (press && map_hit) || rep_push;
    assign push_data = rep_push ? rep_cmd : map_cmd;
`else
    assign push_req  = press && map_hit;
    assign push_data = map_cmd;
`endif

    assign cmd_valid = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop       = cmd_valid && cmd_ready;
    // When full, count is non-zero so cmd_ready alone implies a pop frees a slot
    assign push      = push_req && (!full || cmd_ready);

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            cmd      <= 3'd0;
            overflow <= 1'b0;
        end else begin
            prev     <= key_code;
            overflow <= push_req && !push;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Head register tracks the oldest live entry
            if (push && ((count == '0) || (pop && (count == 1))))
                cmd <= push_data;
            else if (pop && (count > 1))
                cmd <= mem[rd_ptr + 1'b1];
        end
    end
endmodule

// File: tb/tb_key_cmd_queue.sv
// Scoreboard bench for key_cmd_queue; repeat checks are included when KEY_REPEAT_EN is defined.
module tb_key_cmd_queue;
    localparam int DEPTH = 4;
`ifdef KEY_REPEAT_EN
    localparam int DLY  = 20;
    localparam int PER  = 5;
    localparam int HOLD = 15;
`else
    localparam int DLY  = 12_500_000;
    localparam int PER  = 2_500_000;
    localparam int HOLD = 100;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] key_code;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [$clog2(DEPTH):0] count;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    bit exp_ovf = 1'b0;
    logic [8:0] prev_m = '0;

    key_cmd_queue #(.DEPTH(DEPTH), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut (
        .clk(clk), .rst(rst), .key_code(key_code), .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid), .cmd(cmd), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int map_key(input logic [7:0] c);
        case (c)
            8'h77, 8'h57: return 0;
            8'h73, 8'h53: return 1;
            8'h61, 8'h41: return 2;
            8'h64, 8'h44: return 3;
            8'h72, 8'h52: return 4;
            8'h20:        return 5;
            default:      return -1;
        endcase
    endfunction

    // One cycle: check outputs mid-cycle against the scoreboard, then advance it
    task automatic step(input int rep_cmd = -1);
        int  m;
        bit  req, full, popd;
        @(negedge clk);
        chk("count", 32'(count), 32'(exp_q.size()));
        chk("cmd_valid", 32'(cmd_valid), 32'(exp_q.size() != 0));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        if (exp_q.size() != 0) chk("cmd", 32'(cmd), 32'(exp_q[0]));
        if (rst) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            prev_m  = '0;
        end else begin
            m = -1;
            if (key_code[8] && (!prev_m[8] || prev_m[7:0] != key_code[7:0]))
                m = map_key(key_code[7:0]);
            if (rep_cmd >= 0) m = rep_cmd;
            req  = (m >= 0);
            full = (exp_q.size() == DEPTH);
            popd = (exp_q.size() != 0) && cmd_ready;
            if (popd) void'(exp_q.pop_front());
            exp_ovf = 1'b0;
            if (req) begin
                if (!full || popd) exp_q.push_back(m);
                else exp_ovf = 1'b1;
            end
            prev_m = key_code;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tap(input logic [7:0] c);
        key_code = {1'b1, c};
        step();
        key_code = 9'h000;
        step();
    endtask

    initial begin
        rst = 1'b1; key_code = 9'h000; cmd_ready = 1'b0;
        @(posedge clk); #1;
        chk("reset_cmd", 32'(cmd), 32'd0);
        step(); step();
        rst = 1'b0;
        repeat (7) step();

        // Held 'w' yields one command
        key_code = 9'h177;
        repeat (HOLD) step();
        key_code = 9'h000;
        step();
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        step();

        // Five presses into a 4-deep FIFO: fifth drops
        tap(8'h77); tap(8'h73); tap(8'h61); tap(8'h64); tap(8'h20);
        chk("full_count", 32'(count), 32'd4);

        // Push while full with a pop in the same cycle
        key_code = 9'h164; cmd_ready = 1'b1;
        step();
        key_code = 9'h000; cmd_ready = 1'b0;
        step();
        chk("no_ovf_count", 32'(count), 32'd4);

        cmd_ready = 1'b1;
        repeat (5) step();
        cmd_ready = 1'b0;

        // Unmapped key, uppercase key, key change while held
        tap(8'h71);
        tap(8'h41);
        key_code = 9'h177; step();
        key_code = 9'h164; step();
        key_code = 9'h000; step();
        chk("mix_count", 32'(count), 32'd3);

        // Reset with a pending push discards everything
        key_code = 9'h172; rst = 1'b1;
        step();
        rst = 1'b0; key_code = 9'h000;
        step(); step();
        chk("post_rst_count", 32'(count), 32'd0);

`ifdef KEY_REPEAT_EN
        cmd_ready = 1'b1;
        key_code = 9'h173;
        for (int i = 0; i < 40; i++)
            step((i == 20 || i == 25 || i == 30 || i == 35) ? 1 : -1);
        key_code = 9'h000; step(); step();
        key_code = 9'h172;
        repeat (40) step();
        key_code = 9'h000; step(); step();
        cmd_ready = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
